// File: rtl/frame_dump_pkg.sv
// frame_dump_pkg: shared types and constants for the frame dump controller.
//   state_e  - controller FSM state encoding
//   SYNC0/1  - header sync bytes emitted ahead of the payload (header builds)
//   HDR_LEN  - number of header bytes
package frame_dump_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR   = 3'd1,
    FETCH = 3'd2,
    LATCH = 3'd3,
    PACE  = 3'd4,
    SEND  = 3'd5,
    FIN   = 3'd6
  } state_e;

  localparam logic [7:0] SYNC0   = 8'hA5;
  localparam logic [7:0] SYNC1   = 8'h5A;
  localparam int         HDR_LEN = 4;

endpackage

// File: rtl/frame_dump_pacer.sv
// frame_dump_pacer: write pacing for a byte UART producer.
// Counts idle cycles since the UART last reported busy (or since our own
// write) and reports ready once HOLDOFF idle cycles have elapsed.
// Ports:
//   clk_i    - clock (rising edge)
//   rst_i    - synchronous active-high reset; counter starts saturated so the
//              first write after reset is not delayed
//   busy_i   - UART transmitting
//   send_i   - producer issues a write strobe this cycle
//   ready_o  - a write may be issued next cycle
module frame_dump_pacer #(
  parameter int HOLDOFF = 8191
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic busy_i,
  input  logic send_i,
  output logic ready_o
);

  localparam int            CW      = $clog2(HOLDOFF + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(HOLDOFF);

  logic [CW-1:0] holdoff_cnt_q, holdoff_cnt_d;

  // Clearing on our own write covers the gap before the UART raises busy.
  always_comb begin
    holdoff_cnt_d = holdoff_cnt_q;
    if (busy_i || send_i) begin
      holdoff_cnt_d = '0;
    end else if (holdoff_cnt_q != CNT_MAX) begin
      holdoff_cnt_d = holdoff_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      holdoff_cnt_q <= CNT_MAX;
    end else begin
      holdoff_cnt_q <= holdoff_cnt_d;
    end
  end

  assign ready_o = (holdoff_cnt_q == CNT_MAX) && !busy_i;

endmodule

// File: rtl/frame_dump_ctrl.sv
// frame_dump_ctrl: walks a COLS x ROWS word-addressed frame store and streams
// every word MSB-first, byte by byte, into a byte UART.
// Optional feature macro: FRAME_DUMP_HEADER_EN prefixes each dump with
// A5 5A COLS[7:0] ROWS[7:0].
// Ports:
//   sys_clk_i, sys_rst_i  - clock, synchronous active-high reset
//   start_i               - begins a dump when idle (ignored while busy)
//   abort_i               - ends the running dump via FIN
//   read_x_o, read_y_o    - registered read address
//   read_data_i           - word for the address presented one cycle earlier
//   uart_wr_o, uart_dat_o - one-cycle write strobe and its byte
//   uart_busy_i           - UART transmitting
//   busy_o, done_o        - dump in progress, one-cycle completion pulse
// UART handshake: there is no ready input. uart_wr_o is a single-cycle strobe
// issued only after the pacer has seen uart_busy_i low for HOLDOFF cycles
// following the previous strobe; the UART is expected to raise uart_busy_i
// within that window and hold it while the byte is in flight.
module frame_dump_ctrl
  import frame_dump_pkg::*;
#(
  parameter  int COLS           = 40,
  parameter  int ROWS           = 30,
  parameter  int BYTES_PER_WORD = 4,
  parameter  int HOLDOFF        = 8191,
  parameter  int XW             = $clog2(COLS),
  parameter  int YW             = $clog2(ROWS),
  localparam int WORD_W         = 8 * BYTES_PER_WORD
) (
  input  logic              sys_clk_i,
  input  logic              sys_rst_i,
  input  logic              start_i,
  input  logic              abort_i,
  output logic [XW-1:0]     read_x_o,
  output logic [YW-1:0]     read_y_o,
  input  logic [WORD_W-1:0] read_data_i,
  output logic              uart_wr_o,
  output logic [7:0]        uart_dat_o,
  input  logic              uart_busy_i,
  output logic              busy_o,
  output logic              done_o
);

  // Byte index serves both payload words and the header.
  localparam int            IDX_MAX    = (BYTES_PER_WORD > HDR_LEN) ? BYTES_PER_WORD : HDR_LEN;
  localparam int            IW         = $clog2(IDX_MAX);
  localparam logic [IW-1:0] IDX_LAST_W = IW'(BYTES_PER_WORD - 1);
  localparam logic [IW-1:0] IDX_LAST_H = IW'(HDR_LEN - 1);
  localparam logic [XW-1:0] X_LAST     = XW'(COLS - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(ROWS - 1);
  localparam logic [7:0]    COLS_B     = 8'(COLS);
  localparam logic [7:0]    ROWS_B     = 8'(ROWS);

  state_e              state_q, state_d;
  logic [XW-1:0]       x_q, x_d;
  logic [YW-1:0]       y_q, y_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic                hdr_q, hdr_d;
  logic [7:0]          dat_q, dat_d;

  logic                pace_ready;
  logic                send;
  logic [WORD_W-1:0]   word_shifted;
  logic [7:0]          word_byte;
  logic [7:0]          hdr_byte;

  assign send = (state_q == SEND);

  frame_dump_pacer #(
    .HOLDOFF (HOLDOFF)
  ) u_pacer (
    .clk_i   (sys_clk_i),
    .rst_i   (sys_rst_i),
    .busy_i  (uart_busy_i),
    .send_i  (send),
    .ready_o (pace_ready)
  );

  // Shift the selected byte to the top so MSB-first is a fixed slice.
  always_comb begin
    word_shifted = word_q << (8 * idx_q);
    word_byte    = word_shifted[WORD_W-1 -: 8];
  end

  always_comb begin
    case (idx_q)
      IW'(1):  hdr_byte = SYNC1;
      IW'(2):  hdr_byte = COLS_B;
      IW'(3):  hdr_byte = ROWS_B;
      default: hdr_byte = SYNC0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    y_d     = y_q;
    idx_d   = idx_q;
    word_d  = word_q;
    hdr_d   = hdr_q;
    dat_d   = dat_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          x_d   = '0;
          y_d   = '0;
          idx_d = '0;
`ifdef FRAME_DUMP_HEADER_EN
          hdr_d   = 1'b1;
          state_d = HDR;
`else
          hdr_d   = 1'b0;
          state_d = FETCH;
`endif
        end
      end
      HDR: begin
        idx_d   = '0;
        state_d = PACE;
      end
      FETCH: state_d = LATCH;
      LATCH: begin
        word_d  = read_data_i;
        idx_d   = '0;
        state_d = PACE;
      end
      PACE: begin
        if (pace_ready) begin
          dat_d   = hdr_q ? hdr_byte : word_byte;
          state_d = SEND;
        end
      end
      SEND: begin
        if (hdr_q) begin
          if (idx_q == IDX_LAST_H) begin
            hdr_d   = 1'b0;
            idx_d   = '0;
            state_d = FETCH;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = PACE;
          end
        end else if (idx_q != IDX_LAST_W) begin
          idx_d   = idx_q + 1'b1;
          state_d = PACE;
        end else begin
          idx_d = '0;
          if (x_q == X_LAST && y_q == Y_LAST) begin
            state_d = FIN;
          end else begin
            if (x_q == X_LAST) begin
              x_d = '0;
              y_d = y_q + 1'b1;
            end else begin
              x_d = x_q + 1'b1;
            end
            state_d = FETCH;
          end
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // FIN itself is excluded so an abort held high cannot repeat done_o.
    if (abort_i && state_q != IDLE && state_q != FIN) begin
      state_d = FIN;
    end
  end

  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      state_q <= IDLE;
      x_q     <= '0;
      y_q     <= '0;
      idx_q   <= '0;
      word_q  <= '0;
      hdr_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
      idx_q   <= idx_d;
      word_q  <= word_d;
      hdr_q   <= hdr_d;
      dat_q   <= dat_d;
    end
  end

  assign read_x_o   = x_q;
  assign read_y_o   = y_q;
  assign uart_wr_o  = send;
  assign uart_dat_o = dat_q;
  assign busy_o     = (state_q != IDLE);
  assign done_o     = (state_q == FIN);

endmodule
